// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//
// Shared definitions for the UART receive path: default frame geometry
// (data bits, oversampling ratio, stop-bit sample length), the receiver
// state encoding, and a small helper that sizes counters.
//
// Contents:
//   RX_DBIT      default number of data bits per frame (8)
//   RX_SB_TICK   default s_tick count spent on the stop bit (16 = 1 stop bit)
//   RX_OVS       default s_ticks per bit period (16)
//   rx_state_t   2-bit receiver state encoding (IDLE/START/DATA/STOP)
//   cnt_width()  number of bits needed to count 0..n-1 (at least 1)
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int RX_DBIT    = 8;
    localparam int RX_SB_TICK = 16;
    localparam int RX_OVS     = 16;

    // The encoding is fixed so the transmitter side can share the same
    // numbering when states are compared across the two blocks.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Width of a counter that must hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Serial UART receiver for the debug unit. The asynchronous rx line is
// brought into the clk domain through a two-flop synchronizer, oversampled
// with the shared baud tick (s_tick) and deframed as 8N1, LSB first. Each
// byte whose stop bit samples high is presented on dout together with a
// one-clock rx_done_tick; a low stop bit produces a one-clock frame_err
// instead and leaves dout untouched.
//
// Parameters:
//   DBIT      data bits per frame
//   SB_TICK   s_ticks spent sampling the stop bit (16 = one stop bit)
//   OVS       s_ticks per bit period; must be even and at least 4
//
// Ports:
//   clk           in   1     system clock, sole clock domain
//   reset         in   1     synchronous, active-high reset
//   rx            in   1     asynchronous serial line, idle high
//   s_tick        in   1     enable pulse at OVS x baud from the baud generator
//   dout          out  DBIT  last correctly framed byte, held until the next one
//   rx_done_tick  out  1     one-clock strobe, same cycle dout updates
//   frame_err     out  1     one-clock strobe when the stop bit samples low
// ---------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = RX_DBIT,
    parameter int SB_TICK = RX_SB_TICK,
    parameter int OVS     = RX_OVS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    // The tick counter has to reach both OVS-1 (data bits) and SB_TICK-1
    // (stop bit), so it is sized for the larger of the two.
    localparam int S_W = cnt_width((OVS > SB_TICK) ? OVS : SB_TICK);
    localparam int N_W = cnt_width(DBIT);

    // Terminal counts, pre-cast to counter width so every compare is
    // width-exact.
    localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    rx_state_t        state;
    logic [S_W-1:0]   s;
    logic [N_W-1:0]   n;
    logic [DBIT-1:0]  shreg;
    logic             rx_meta;
    logic             rx_s;

    // Everything lives in one clocked block: the synchronizer flops, the
    // receiver state machine, its counters and the registered outputs.
    //
    // The synchronizer resets to 1 so a line that is low while reset is
    // released is seen as a fresh falling edge two clocks later rather than
    // as a frame already in progress.
    //
    // The strobes default low every clock and are only set on the single
    // clock that leaves STOP. Because STOP is left on that same clock, a
    // wide s_tick cannot re-trigger them: IDLE ignores s_tick entirely.
    //
    // IDLE watches rx_s on every clock, not only on ticks, so a start bit
    // that follows a stop bit with no gap is picked up immediately.
    //
    // START counts half a bit and then re-checks the line; a line that has
    // already gone high again is treated as noise and dropped silently.
    // After that, counting a full bit period per data bit lands each sample
    // in the middle of its bit, and the stop bit is sampled SB_TICK ticks
    // after the last data sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end

                START: begin
                    if (s_tick) begin
                        if (s == S_MID) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DBIT-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            state <= IDLE;
                            if (rx_s) begin
                                dout         <= shreg;
                                rx_done_tick <= 1'b1;
                            end else begin
                                frame_err    <= 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
